// File: rtl/ds_frame_align.sv
// Serial-to-parallel deserializer with sync-word frame alignment.
// Hunts for SYNC_WORD bit by bit, then tracks a frame of one sync slot
// followed by FRAME_WORDS data slots, dropping lock after MISS_MAX
// consecutive bad sync slots.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_HUNT   | sliding bit-by-bit search for SYNC_WORD, no data output
// S_LOCKED | word boundary known, data slots delivered, sync slots checked
module ds_frame_align #(
   parameter int               WIDTH       = 8,
   parameter bit               LSB_FIRST   = 1'b1,
   parameter logic [WIDTH-1:0] SYNC_WORD   = WIDTH'(8'hA5),
   parameter int               FRAME_WORDS = 4,
   parameter int               MISS_MAX    = 2
) (
   input  logic             clock_40,
   input  logic             reset,
   input  logic             enable,
   input  logic             data_in,
   input  logic             align_req,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   output logic             locked,
   output logic             sync_err,
   output logic [15:0]      word_count
);

   localparam int FILL_W = $clog2(WIDTH + 1);
   localparam int BIT_W  = $clog2(WIDTH);
   localparam int SLOT_W = $clog2(FRAME_WORDS + 1);
   localparam int MISS_W = $clog2(MISS_MAX + 1);

   localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(WIDTH);
   localparam logic [FILL_W-1:0] FILL_PRE   = FILL_W'(WIDTH - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(WIDTH - 1);
   localparam logic [SLOT_W-1:0] SLOT_SYNC  = SLOT_W'(FRAME_WORDS);
   localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(MISS_MAX);

   typedef enum logic [0:0] {
      S_HUNT   = 1'b0,
      S_LOCKED = 1'b1
   } state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_sr;
   logic [FILL_W-1:0]  r_fill;
   logic [BIT_W-1:0]   r_bit;
   logic [SLOT_W-1:0]  r_slot;
   logic [MISS_W-1:0]  r_miss;
   logic [WIDTH-1:0]   r_data;
   logic               r_valid;
   logic               r_err;
   logic [15:0]        r_count;

   state_t             w_state_nxt;
   logic [WIDTH-1:0]   w_sr_shift;
   logic [WIDTH-1:0]   w_sr_nxt;
   logic [FILL_W-1:0]  w_fill_nxt;
   logic [BIT_W-1:0]   w_bit_nxt;
   logic [SLOT_W-1:0]  w_slot_nxt;
   logic [MISS_W-1:0]  w_miss_nxt;
   logic [MISS_W-1:0]  w_miss_inc;
   logic [WIDTH-1:0]   w_data_nxt;
   logic               w_valid_nxt;
   logic               w_err_nxt;
   logic [15:0]        w_count_nxt;
   logic               w_sync_hit;

   // Shift register input: the bit sampled on this edge, in the configured order.
   generate
      if (LSB_FIRST) begin : g_lsb
         assign w_sr_shift = {data_in, r_sr[WIDTH-1:1]};
      end else begin : g_msb
         assign w_sr_shift = {r_sr[WIDTH-2:0], data_in};
      end
   endgenerate

   assign w_sync_hit = (w_sr_shift == SYNC_WORD);
   assign w_miss_inc = r_miss + 1'b1;

   // Next-state and datapath decisions; pulses default low so they never stretch.
   always_comb begin
      w_state_nxt = r_state;
      w_sr_nxt    = r_sr;
      w_fill_nxt  = r_fill;
      w_bit_nxt   = r_bit;
      w_slot_nxt  = r_slot;
      w_miss_nxt  = r_miss;
      w_data_nxt  = r_data;
      w_valid_nxt = 1'b0;
      w_err_nxt   = 1'b0;
      w_count_nxt = r_count;
      if (align_req) begin
         w_state_nxt = S_HUNT;
         w_fill_nxt  = '0;
         w_bit_nxt   = '0;
         w_slot_nxt  = '0;
         w_miss_nxt  = '0;
      end else if (enable) begin
         w_sr_nxt = w_sr_shift;
         case (r_state)
            S_HUNT: begin
               if (r_fill != FILL_FULL) begin
                  w_fill_nxt = r_fill + 1'b1;
               end
               if ((r_fill >= FILL_PRE) && w_sync_hit) begin
                  w_state_nxt = S_LOCKED;
                  w_bit_nxt   = '0;
                  w_slot_nxt  = '0;
                  w_miss_nxt  = '0;
               end
            end
            S_LOCKED: begin
               if (r_bit == BIT_LAST) begin
                  w_bit_nxt = '0;
                  if (r_slot != SLOT_SYNC) begin
                     // Data slot: content is deliberately not inspected.
                     w_data_nxt  = w_sr_shift;
                     w_valid_nxt = 1'b1;
                     w_count_nxt = r_count + 16'd1;
                     w_slot_nxt  = r_slot + 1'b1;
                  end else begin
                     w_slot_nxt = '0;
                     if (w_sync_hit) begin
                        w_miss_nxt = '0;
                     end else begin
                        w_err_nxt  = 1'b1;
                        w_miss_nxt = w_miss_inc;
                        if (w_miss_inc == MISS_LIMIT) begin
                           w_state_nxt = S_HUNT;
                           w_fill_nxt  = '0;
                        end
                     end
                  end
               end else begin
                  w_bit_nxt = r_bit + 1'b1;
               end
            end
            default: w_state_nxt = S_HUNT;
         endcase
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clock_40) begin
      if (reset) begin
         r_state <= S_HUNT;
         r_sr    <= '0;
         r_fill  <= '0;
         r_bit   <= '0;
         r_slot  <= '0;
         r_miss  <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         r_count <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_sr    <= w_sr_nxt;
         r_fill  <= w_fill_nxt;
         r_bit   <= w_bit_nxt;
         r_slot  <= w_slot_nxt;
         r_miss  <= w_miss_nxt;
         r_data  <= w_data_nxt;
         r_valid <= w_valid_nxt;
         r_err   <= w_err_nxt;
         r_count <= w_count_nxt;
      end
   end

   assign data_out   = r_data;
   assign data_valid = r_valid;
   assign locked     = (r_state == S_LOCKED);
   assign sync_err   = r_err;
   assign word_count = r_count;

endmodule

// File: tb/tb_ds_frame_align.sv
// Scoreboard bench for ds_frame_align: default LSB-first instance plus
// an MSB-first instance for the bit-order variant.
module tb_ds_frame_align;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        a_en = 1'b0, a_din = 1'b0, a_align = 1'b0;
   logic [7:0]  a_data;
   logic        a_dv, a_locked, a_err;
   logic [15:0] a_wc;
   logic        b_en = 1'b0, b_din = 1'b0, b_align = 1'b0;
   logic [7:0]  b_data;
   logic        b_dv, b_locked, b_err;
   logic [15:0] b_wc;

   int          n_total = 0;
   int          n_bad = 0;
   int          err_cnt = 0;
   int          cyc = 0;
   int          last_dv_cyc = -1;
   bit          spacing_on = 1'b0;
   logic        last_en = 1'b0;
   logic        prev_dv = 1'b0;
   logic        prev_err = 1'b0;
   logic [7:0]  exp_q[$];

   always #5 clk = ~clk;

   ds_frame_align u_dut_a (
      .clock_40(clk), .reset(reset), .enable(a_en), .data_in(a_din),
      .align_req(a_align), .data_out(a_data), .data_valid(a_dv),
      .locked(a_locked), .sync_err(a_err), .word_count(a_wc)
   );

   ds_frame_align #(.LSB_FIRST(1'b0)) u_dut_b (
      .clock_40(clk), .reset(reset), .enable(b_en), .data_in(b_din),
      .align_req(b_align), .data_out(b_data), .data_valid(b_dv),
      .locked(b_locked), .sync_err(b_err), .word_count(b_wc)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      last_en <= a_en;
      cyc     <= cyc + 1;
   end

   // Output monitor: pops the scoreboard on every strobe.
   always @(negedge clk) begin
      if (a_dv) begin
         if (exp_q.size() == 0) check_val("dv_unexpected", a_dv, 0);
         else check_val("data_out", a_data, exp_q.pop_front());
         if (spacing_on && last_dv_cyc >= 0) check_val("dv_spacing", cyc - last_dv_cyc, 8);
         last_dv_cyc = cyc;
      end
      if (!last_en) check_val("dv_without_en", a_dv, 0);
      if (prev_dv) check_val("dv_width", a_dv, 0);
      if (prev_err) check_val("err_width", a_err, 0);
      if (a_err) err_cnt++;
      prev_dv  = a_dv;
      prev_err = a_err;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      a_din = b;
      a_en  = 1'b1;
      tick();
   endtask

   task automatic send_word(input logic [7:0] w, input bit gaps);
      for (int i = 0; i < 8; i++) begin
         if (gaps && (i == 2 || i == 5)) begin
            a_en = 1'b0;
            repeat ($urandom_range(1, 5)) begin
               a_din = 1'($urandom);
               tick();
            end
         end
         send_bit(w[i]);
      end
   endtask

   task automatic idle(input int n);
      a_en = 1'b0;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      a_en  = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check_val("rst_data", a_data, 0);
      check_val("rst_dv", a_dv, 0);
      check_val("rst_locked", a_locked, 0);
      check_val("rst_err", a_err, 0);
      check_val("rst_wc", a_wc, 0);
   endtask

   task automatic junk_and_sync();
      logic [7:0] sw;
      sw = 8'hA5;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      for (int i = 0; i < 7; i++) send_bit(sw[i]);
      check_val("pre_lock", a_locked, 0);
      send_bit(sw[7]);
      check_val("lock", a_locked, 1);
      check_val("lock_no_dv", a_dv, 0);
   endtask

   task automatic push_send(input logic [7:0] w, input bit gaps);
      exp_q.push_back(w);
      send_word(w, gaps);
   endtask

   initial begin
      logic [7:0] bseq;
      do_reset();

      // Clean frame, continuous enable.
      spacing_on = 1'b1;
      junk_and_sync();
      push_send(8'h01, 0);
      push_send(8'h02, 0);
      push_send(8'h03, 0);
      push_send(8'h04, 0);
      spacing_on = 1'b0;
      idle(2);
      check_val("t1_wc", a_wc, 4);
      check_val("t1_errs", err_cnt, 0);
      check_val("t1_q_empty", exp_q.size(), 0);

      // Same stream with enable gaps mid-word.
      do_reset();
      junk_and_sync();
      push_send(8'h11, 1);
      push_send(8'h22, 1);
      push_send(8'h33, 1);
      push_send(8'h44, 1);
      check_val("t2_wc", a_wc, 4);
      check_val("t2_locked", a_locked, 1);

      // Two consecutive bad sync slots.
      send_word(8'h00, 0);
      check_val("miss1_err", a_err, 1);
      check_val("miss1_locked", a_locked, 1);
      push_send(8'h05, 0);
      push_send(8'h06, 0);
      push_send(8'h07, 0);
      push_send(8'h08, 0);
      send_word(8'h00, 1);
      check_val("miss2_err", a_err, 1);
      check_val("miss2_unlocked", a_locked, 0);
      send_word(8'h00, 0);
      send_word(8'h00, 0);
      check_val("hunt_locked", a_locked, 0);
      check_val("t3_wc", a_wc, 8);
      check_val("t3_errs", err_cnt, 2);
      send_word(8'hA5, 0);
      check_val("relock", a_locked, 1);

      // Sync pattern inside a data slot is plain data.
      push_send(8'h01, 0);
      push_send(8'hA5, 0);
      check_val("a5_locked", a_locked, 1);
      push_send(8'h02, 0);
      push_send(8'h03, 0);
      send_word(8'hA5, 0);
      push_send(8'h5A, 0);
      check_val("t4_wc", a_wc, 13);
      check_val("t4_errs", err_cnt, 2);
      check_val("t4_locked", a_locked, 1);

      // Reset at bit 5 of a data word.
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      do_reset();
      junk_and_sync();
      push_send(8'h77, 0);
      check_val("t5_wc", a_wc, 1);

      // align_req mid-frame, during a partial word.
      push_send(8'h81, 0);
      push_send(8'h82, 0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      a_align = 1'b1;
      a_en    = 1'b1;
      a_din   = 1'b1;
      tick();
      a_align = 1'b0;
      a_en    = 1'b0;
      check_val("align_locked", a_locked, 0);
      check_val("align_data", a_data, 8'h82);
      check_val("align_wc", a_wc, 3);
      check_val("align_dv", a_dv, 0);
      send_word(8'hA5, 0);
      check_val("align_relock", a_locked, 1);
      push_send(8'h3C, 0);
      check_val("t6_wc", a_wc, 4);
      idle(3);

      // MSB-first instance.
      bseq = 8'hA5;
      for (int i = 7; i >= 0; i--) begin
         b_din = bseq[i];
         b_en  = 1'b1;
         tick();
      end
      check_val("b_lock", b_locked, 1);
      bseq = 8'h3C;
      for (int i = 7; i >= 0; i--) begin
         b_din = bseq[i];
         b_en  = 1'b1;
         tick();
      end
      b_en = 1'b0;
      check_val("b_dv", b_dv, 1);
      check_val("b_data", b_data, 8'h3C);
      check_val("b_wc", b_wc, 1);
      tick();
      check_val("b_dv_low", b_dv, 0);

      idle(2);
      check_val("q_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
